spi_cmd_slave: RTL and testbench

- SPI slave front end for the MSX slot bridge. Deserialises framed host transactions (command, 16-bit address, data) into a parallel request for the downstream msxbus stage, and serialises the returned read byte back on miso.
- Sits directly upstream of the bus-cycle engine. Provides its cmd/addr/wdata/req inputs and consumes its rdata/rdata_valid outputs.

---
 rtl/msxbus_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_cmd_slave.sv | 168 ++++++++++++++++
 tb/tb_spi_cmd_slave.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/msxbus_pkg.sv
// Shared definitions for the MSX slot bridge: command bit positions,
// SPI front-end state encoding and the idle byte returned on miso.
package msxbus_pkg;

    localparam int CMD_RW  = 7;
    localparam int CMD_MEM = 6;
    localparam int CMD_SLT = 5;

    localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_H,
        ADDR_L,
        WDATA,
        TURN,
        RDATA,
        DRAIN
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with single-clk rise/fall pulses derived from
// the last two synchronised samples.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 slave: deframes cmd/addr/wdata into a parallel request for the
// bus-cycle engine and returns the read byte on miso.
module spi_cmd_slave
    import msxbus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TURN_BYTES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    input  logic        scs,
    output logic [7:0]  cmd,
    output logic [15:0] addr,
    output logic [7:0]  wdata,
    output logic        req,
    input  logic [7:0]  rdata,
    input  logic        rdata_valid,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] TURN_LAST = 2'(TURN_BYTES - 1);

    logic sclk_q_unused, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise_unused, mosi_fall_unused;
    logic scs_q, scs_rise, scs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .d(sclk),
        .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .d(mosi),
        .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scs (
        .clk(clk), .reset(reset), .d(scs),
        .q(scs_q), .rise(scs_rise), .fall(scs_fall)
    );

    spi_state_t  state;
    logic [2:0]  bitcnt;
    logic [6:0]  shreg;
    logic [1:0]  turn_cnt;
    logic [7:0]  cmd_s, wdata_s, rbuf;
    logic [15:0] addr_s;
    logic [6:0]  txsh;
    logic        rbuf_ok, rd_arm, req_pend, req_done;
    logic [7:0]  byte_in, tx_byte;
    logic        byte_end;

    assign byte_in  = {shreg, mosi_q};
    assign byte_end = sclk_rise && (bitcnt == 3'd7);
    assign tx_byte  = rbuf_ok ? rbuf : SPI_IDLE_BYTE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bitcnt   <= 3'd0;
            shreg    <= 7'd0;
            turn_cnt <= 2'd0;
            cmd_s    <= 8'd0;
            addr_s   <= 16'd0;
            wdata_s  <= 8'd0;
            cmd      <= 8'd0;
            addr     <= 16'd0;
            wdata    <= 8'd0;
            rbuf     <= SPI_IDLE_BYTE;
            rbuf_ok  <= 1'b0;
            rd_arm   <= 1'b0;
            txsh     <= 7'h7F;
            req_pend <= 1'b0;
            req_done <= 1'b0;
            req      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            miso     <= 1'b1;
        end else begin
            req      <= req_pend;
            req_pend <= 1'b0;
            err      <= 1'b0;
            // Outputs move only together with req so an aborted frame leaves them intact.
            if (req_pend) begin
                cmd  <= cmd_s;
                addr <= addr_s;
                if (cmd_s[CMD_RW]) wdata <= wdata_s;
            end
            if (rd_arm && rdata_valid && !scs_q) begin
                rbuf    <= rdata;
                rbuf_ok <= 1'b1;
            end
            if (state == IDLE) begin
                rbuf_ok  <= 1'b0;
                req_done <= 1'b0;
            end

            if (scs_q) begin
                if (scs_rise) begin
                    busy <= 1'b0;
                    err  <= !req_done && (bitcnt != 3'd0 || (state != IDLE && state != CMD));
                end
                state  <= IDLE;
                bitcnt <= 3'd0;
                rd_arm <= 1'b0;
                miso   <= 1'b1;
            end else if (state == IDLE) begin
                if (scs_fall) begin
                    state <= CMD;
                    busy  <= 1'b1;
                end
            end else begin
                if (sclk_rise) begin
                    shreg  <= byte_in[6:0];
                    bitcnt <= bitcnt + 3'd1;
                end
                if (byte_end) begin
                    unique case (state)
                        CMD:    begin cmd_s <= byte_in; state <= ADDR_H; end
                        ADDR_H: begin addr_s[15:8] <= byte_in; state <= ADDR_L; end
                        ADDR_L: begin
                            addr_s[7:0] <= byte_in;
                            if (cmd_s[CMD_RW]) begin
                                state <= WDATA;
                            end else begin
                                req_pend <= 1'b1;
                                req_done <= 1'b1;
                                rd_arm   <= 1'b1;
                                turn_cnt <= 2'd0;
                                state    <= TURN;
                            end
                        end
                        WDATA: begin
                            wdata_s  <= byte_in;
                            req_pend <= 1'b1;
                            req_done <= 1'b1;
                            state    <= DRAIN;
                        end
                        TURN: begin
                            if (turn_cnt == TURN_LAST) begin
                                rd_arm <= 1'b0;
                                txsh   <= tx_byte[6:0];
                                miso   <= tx_byte[7];
                                err    <= !rbuf_ok;
                                state  <= RDATA;
                            end else begin
                                turn_cnt <= turn_cnt + 2'd1;
                            end
                        end
                        RDATA: begin
                            miso  <= 1'b1;
                            state <= DRAIN;
                        end
                        default: ;
                    endcase
                end
                // The trailing fall of the last TURN bit lands with bitcnt==0 and must not shift.
                if (sclk_fall && state == RDATA && bitcnt != 3'd0) begin
                    miso <= txsh[6];
                    txsh <= {txsh[5:0], 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed bench for spi_cmd_slave: write, read, missing rdata, abort,
// trailing bytes and mid-frame reset, with mode-0 host timing at clk = 8x sclk.
module tb_spi_cmd_slave;
    import msxbus_pkg::*;

    localparam int  SYNC_STAGES = 2;
    localparam int  TURN_BYTES  = 1;
    localparam time LAT         = (SYNC_STAGES + 2) * 10;

    logic        clk = 1'b0, reset = 1'b0, sclk = 1'b0, mosi = 1'b0, scs = 1'b1;
    logic        rdata_valid = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        miso, req, busy, err;
    logic [7:0]  cmd, wdata;
    logic [15:0] addr;

    int  errors = 0, checks = 0;
    int  req_cnt = 0, err_cnt = 0, busy_bad = 0, resp_cnt = 0;
    bit  in_frame = 0, resp_en = 0;
    time req_time = 0, last_rise = 0, t_last = 0;
    logic [7:0] resp_byte = 8'h00;

    spi_cmd_slave #(.SYNC_STAGES(SYNC_STAGES), .TURN_BYTES(TURN_BYTES)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .miso(miso), .scs(scs),
        .cmd(cmd), .addr(addr), .wdata(wdata), .req(req), .rdata(rdata),
        .rdata_valid(rdata_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Pulse counters plus the bus-stage responder (rdata_valid 4 clk after req).
    always @(negedge clk) begin
        rdata_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                rdata       = resp_byte;
                rdata_valid = 1'b1;
            end
        end
        if (req === 1'b1) begin
            req_cnt++;
            req_time = $time;
            if (resp_en) resp_cnt = 4;
        end
        if (err === 1'b1) err_cnt++;
        if (in_frame && busy !== 1'b1) busy_bad++;
    end

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            #40;
            rx[i] = miso;
            sclk = 1'b1;
            last_rise = $time;
            #40;
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        req_cnt = 0; err_cnt = 0; busy_bad = 0;
        scs = 1'b0;
        #80;
        in_frame = 1;
    endtask

    task automatic frame_end();
        #80;
        in_frame = 0;
        scs = 1'b1;
        #160;
    endtask

    // Read frame with the TURN bytes; returns the byte seen in the RDATA slot.
    task automatic read_frame(input logic [7:0] c, input logic [15:0] a, output logic [7:0] rx);
        logic [7:0] d;
        frame_begin();
        spi_bits(c, 8, d);
        spi_bits(a[15:8], 8, d);
        spi_bits(a[7:0], 8, d);
        t_last = last_rise;
        for (int t = 0; t < TURN_BYTES; t++) spi_bits(8'h00, 8, d);
        spi_bits(8'h00, 8, rx);
        frame_end();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #30;
        checks++;
        if ({miso, req, busy, err, cmd, addr, wdata} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got miso=%b req=%b busy=%b err=%b cmd=%h addr=%h wdata=%h, want 1 0 0 0 00 0000 00",
                     miso, req, busy, err, cmd, addr, wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        #40;
    endtask

    task automatic test_write_frame();
        logic [7:0] rx, rx_and;
        logic [7:0] bytes [4] = '{8'hC0, 8'h40, 8'h12, 8'h5A};
        rx_and = 8'hFF;
        frame_begin();
        foreach (bytes[i]) begin
            spi_bits(bytes[i], 8, rx);
            rx_and &= rx;
        end
        t_last = last_rise;
        frame_end();
        checks++; if (req_cnt !== 1) begin errors++; $display("FAIL wr_req_count: got %0d want 1", req_cnt); end
        checks++; if (cmd !== 8'hC0) begin errors++; $display("FAIL wr_cmd: got %h want c0", cmd); end
        checks++; if (addr !== 16'h4012) begin errors++; $display("FAIL wr_addr: got %h want 4012", addr); end
        checks++; if (wdata !== 8'h5A) begin errors++; $display("FAIL wr_wdata: got %h want 5a", wdata); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL wr_err: got %0d pulses want 0", err_cnt); end
        checks++; if (busy_bad !== 0 || busy !== 1'b0) begin errors++; $display("FAIL wr_busy: low-in-frame=%0d after=%b want 0 0", busy_bad, busy); end
        checks++; if (req_time - t_last !== LAT) begin errors++; $display("FAIL wr_latency: got %0t want %0t", req_time - t_last, LAT); end
        checks++; if (rx_and !== 8'hFF) begin errors++; $display("FAIL wr_miso_idle: got %h want ff", rx_and); end
    endtask

    task automatic test_read_frame();
        logic [7:0] rx;
        resp_en = 1; resp_byte = 8'h3C;
        read_frame(8'h40, 16'h0080, rx);
        resp_en = 0;
        checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL rd_miso: got %h want 3c", rx); end
        checks++; if (req_cnt !== 1) begin errors++; $display("FAIL rd_req_count: got %0d want 1", req_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rd_err: got %0d want 0", err_cnt); end
        checks++; if ({cmd, addr, wdata} !== {8'h40, 16'h0080, 8'h5A}) begin errors++; $display("FAIL rd_latched: got %h %h %h want 40 0080 5a", cmd, addr, wdata); end
        checks++; if (req_time - t_last !== LAT) begin errors++; $display("FAIL rd_latency: got %0t want %0t", req_time - t_last, LAT); end
    endtask

    task automatic test_read_nodata();
        logic [7:0] rx;
        read_frame(8'h40, 16'h1234, rx);
        checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL nd_miso: got %h want ff", rx); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL nd_err: got %0d want 1", err_cnt); end
        checks++; if (req_cnt !== 1) begin errors++; $display("FAIL nd_req_count: got %0d want 1", req_cnt); end
        checks++; if ({cmd, addr} !== {8'h40, 16'h1234}) begin errors++; $display("FAIL nd_latched: got %h %h want 40 1234", cmd, addr); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        frame_begin();
        spi_bits(8'hC0, 8, rx);
        spi_bits(8'h40, 4, rx);
        frame_end();
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL ab_req: got %0d want 0", req_cnt); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL ab_err: got %0d want 1", err_cnt); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL ab_state: got %0d want IDLE", dut.state); end
        checks++; if ({cmd, addr} !== {8'h40, 16'h1234}) begin errors++; $display("FAIL ab_kept: got %h %h want 40 1234", cmd, addr); end
        frame_begin();
        spi_bits(8'hC0, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h01, 8, rx);
        spi_bits(8'h77, 8, rx);
        frame_end();
        checks++; if (req_cnt !== 1) begin errors++; $display("FAIL ab_next_req: got %0d want 1", req_cnt); end
        checks++; if ({cmd, addr, wdata} !== {8'hC0, 16'h0001, 8'h77}) begin errors++; $display("FAIL ab_next_data: got %h %h %h want c0 0001 77", cmd, addr, wdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx, rx_and;
        logic [7:0] bytes [7] = '{8'hC0, 8'h40, 8'h12, 8'h5A, 8'hAA, 8'h55, 8'h00};
        rx_and = 8'hFF;
        frame_begin();
        foreach (bytes[i]) begin
            spi_bits(bytes[i], 8, rx);
            if (i >= 4) rx_and &= rx;
        end
        frame_end();
        checks++; if (req_cnt !== 1) begin errors++; $display("FAIL ex_req_count: got %0d want 1", req_cnt); end
        checks++; if (rx_and !== 8'hFF) begin errors++; $display("FAIL ex_drain_miso: got %h want ff", rx_and); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL ex_err: got %0d want 0", err_cnt); end
        checks++; if ({addr, wdata} !== {16'h4012, 8'h5A}) begin errors++; $display("FAIL ex_data: got %h %h want 4012 5a", addr, wdata); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rx;
        frame_begin();
        spi_bits(8'hC0, 8, rx);
        spi_bits(8'h40, 3, rx);
        in_frame = 0;
        #13;
        reset = 1'b0;
        #1;
        checks++;
        if ({miso, req, busy, err, cmd, addr, wdata} !== {4'b1000, 32'h0} || dut.state !== IDLE) begin
            errors++;
            $display("FAIL rst_mid: got miso=%b req=%b busy=%b err=%b cmd=%h addr=%h wdata=%h state=%0d, want reset values",
                     miso, req, busy, err, cmd, addr, wdata, dut.state);
        end
        scs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #40;
        @(negedge clk);
        reset = 1'b1;
        #40;
        checks++; if (req_cnt !== 0) begin errors++; $display("FAIL rst_no_req: got %0d want 0", req_cnt); end
        resp_en = 1; resp_byte = 8'hA5;
        read_frame(8'h00, 16'h0098, rx);
        resp_en = 0;
        checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL rst_rd_miso: got %h want a5", rx); end
        checks++; if ({req_cnt, err_cnt} !== {32'd1, 32'd0}) begin errors++; $display("FAIL rst_rd_pulses: req=%0d err=%0d want 1 0", req_cnt, err_cnt); end
        checks++; if ({cmd, addr} !== {8'h00, 16'h0098}) begin errors++; $display("FAIL rst_rd_latched: got %h %h want 00 0098", cmd, addr); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_frame();
        test_read_frame();
        test_read_nodata();
        test_abort();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
